// File: rtl/lcd_rgb_rx.sv
// lcd_rgb_rx: DE-mode RGB565 receiver that recovers frame/line timing from lcd_de alone
module lcd_rgb_rx #(
  parameter int VBLANK_MIN = 1024,
  parameter int CNT_W = 11
) (
  input  logic             lcd_pclk,
  input  logic             rst_n,
  input  logic             lcd_de,
  input  logic [15:0]      lcd_rgb,
  output logic             pix_valid,
  output logic [15:0]      pix_data,
  output logic [CNT_W-1:0] pix_x,
  output logic [CNT_W-1:0] pix_y,
  output logic             frame_start,
  output logic             line_end,
  output logic             frame_end,
  output logic [CNT_W-1:0] meas_h_disp,
  output logic [CNT_W-1:0] meas_v_disp,
  output logic             meas_valid,
  output logic             locked,
  output logic             line_err
);
  localparam logic [1:0] SEEK = 2'd0, VBLANK = 2'd1, ACTIVE = 2'd2, HBLANK = 2'd3;
  localparam int LW = $clog2(VBLANK_MIN + 1);
  localparam logic [LW-1:0] LOW_MAX = LW'(VBLANK_MIN);
  logic [1:0] state;
  logic [LW-1:0] low_cnt;
  logic [CNT_W-1:0] len, ref_len;
  logic vb_hit;
  function automatic logic [CNT_W-1:0] sat(input logic [CNT_W-1:0] v);
    return &v ? v : v + 1'b1;
  endfunction
  // true on the sample that completes a run of VBLANK_MIN consecutive DE-low cycles
  assign vb_hit = !lcd_de && (low_cnt >= LOW_MAX - 1'b1);
  always_ff @(posedge lcd_pclk or negedge rst_n)
    if (!rst_n) low_cnt <= '0;
    else low_cnt <= lcd_de ? '0 : (low_cnt == LOW_MAX ? low_cnt : low_cnt + 1'b1);
  always_ff @(posedge lcd_pclk or negedge rst_n)
    if (!rst_n) begin
      state       <= SEEK;
      pix_valid   <= 1'b0;
      pix_data    <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      meas_h_disp <= '0;
      meas_v_disp <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      line_err    <= 1'b0;
      len         <= '0;
      ref_len     <= '0;
    end else begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_end   <= 1'b0;
      line_err    <= 1'b0;
      case (state)
        SEEK:
          if (vb_hit) begin
            state  <= VBLANK;
            locked <= 1'b1;
          end
        VBLANK:
          if (lcd_de) begin
            state       <= ACTIVE;
            pix_valid   <= 1'b1;
            pix_data    <= lcd_rgb;
            pix_x       <= '0;
            pix_y       <= '0;
            len         <= CNT_W'(1);
            ref_len     <= '0;
            frame_start <= 1'b1;
          end
        ACTIVE:
          if (lcd_de) begin
            pix_valid <= 1'b1;
            pix_data  <= lcd_rgb;
            pix_x     <= sat(pix_x);
            len       <= sat(len);
          end else begin
            state    <= HBLANK;
            line_end <= 1'b1;
            if (pix_y == '0) ref_len <= len;
            else line_err <= (len != ref_len);
          end
        default:
          if (lcd_de) begin
            state     <= ACTIVE;
            pix_valid <= 1'b1;
            pix_data  <= lcd_rgb;
            pix_x     <= '0;
            pix_y     <= sat(pix_y);
            len       <= CNT_W'(1);
          end else if (vb_hit) begin
            state       <= VBLANK;
            frame_end   <= 1'b1;
            meas_h_disp <= ref_len;
            meas_v_disp <= sat(pix_y);
            meas_valid  <= 1'b1;
          end
      endcase
    end
endmodule

// File: tb/tb_lcd_rgb_rx.sv
// tb_lcd_rgb_rx: frame-table, hand-written corner sequences and random frames checked cycle by cycle
module tb_lcd_rgb_rx;
  localparam int VB = 1024;
  localparam int W = 11;
  localparam int MAXC = (1 << W) - 1;
  logic lcd_pclk, rst_n, lcd_de;
  logic [15:0] lcd_rgb;
  logic pix_valid, frame_start, line_end, frame_end, meas_valid, locked, line_err;
  logic [15:0] pix_data;
  logic [W-1:0] pix_x, pix_y, meas_h_disp, meas_v_disp;
  lcd_rgb_rx #(.VBLANK_MIN(VB), .CNT_W(W)) dut (
    .lcd_pclk(lcd_pclk), .rst_n(rst_n), .lcd_de(lcd_de), .lcd_rgb(lcd_rgb),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start), .line_end(line_end), .frame_end(frame_end),
    .meas_h_disp(meas_h_disp), .meas_v_disp(meas_v_disp), .meas_valid(meas_valid),
    .locked(locked), .line_err(line_err)
  );
  initial lcd_pclk = 1'b0;
  always #5 lcd_pclk = ~lcd_pclk;
  typedef struct {
    int h; int v; int hb; int vb; int short_line; bit ramp; int exp_h; int exp_v;
  } frame_t;
  frame_t tbl[7];
  int vectors = 0, miscompares = 0;
  int n_pv = 0, n_le = 0, n_fe = 0, n_err = 0, n_fs = 0;
  bit m_in, m_prev;
  int m_low, m_cur;
  int m_lens[$];
  logic e_valid, e_fs, e_le, e_fe, e_mvld, e_locked, e_err;
  logic [15:0] e_data;
  logic [W-1:0] e_x, e_y, e_mh, e_mv;
  function automatic int sat(input int v);
    return v > MAXC ? MAXC : v;
  endfunction
  task automatic model_reset();
    m_in = 0; m_prev = 0; m_low = 0; m_cur = 0; m_lens.delete();
    {e_valid, e_fs, e_le, e_fe, e_mvld, e_locked, e_err} = '0;
    e_data = '0; e_x = '0; e_y = '0; e_mh = '0; e_mv = '0;
  endtask
  // frame/line structure derived from DE run lengths and a list of finished line lengths
  task automatic model_step(input bit de, input logic [15:0] rgb);
    {e_valid, e_fs, e_le, e_fe, e_err} = '0;
    if (de) begin
      if (m_in || e_locked) begin
        if (!m_in) begin
          m_in = 1; m_lens.delete(); m_cur = 1; e_fs = 1;
        end else if (!m_prev) m_cur = 1;
        else m_cur++;
        e_valid = 1; e_data = rgb;
        e_x = W'(sat(m_cur - 1));
        e_y = W'(sat(m_lens.size()));
      end
      m_low = 0;
    end else begin
      m_low++;
      if (m_in && m_prev) begin
        e_le = 1;
        m_lens.push_back(m_cur);
        e_err = (m_lens.size() > 1) && (sat(m_cur) != sat(m_lens[0]));
      end
      if (m_low == VB) begin
        if (!e_locked) e_locked = 1;
        else if (m_in) begin
          m_in = 0; e_fe = 1; e_mvld = 1;
          e_mh = W'(sat(m_lens[0]));
          e_mv = W'(sat(m_lens.size()));
        end
      end
    end
    m_prev = de;
  endtask
  task automatic check(input string name);
    logic [67:0] act, exp;
    act = {pix_valid, pix_data, pix_x, pix_y, frame_start, line_end, frame_end,
           meas_h_disp, meas_v_disp, meas_valid, locked, line_err};
    exp = {e_valid, e_data, e_x, e_y, e_fs, e_le, e_fe, e_mh, e_mv, e_mvld, e_locked, e_err};
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, exp);
    end
  endtask
  task automatic check_int(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask
  task automatic step(input bit de, input logic [15:0] rgb);
    lcd_de = de; lcd_rgb = rgb;
    @(posedge lcd_pclk);
    model_step(de, rgb);
    #1;
    check("cycle");
    n_pv += int'(pix_valid); n_le += int'(line_end); n_fe += int'(frame_end);
    n_err += int'(line_err); n_fs += int'(frame_start);
  endtask
  task automatic lows(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 16'($urandom));
  endtask
  task automatic frame(input int h, input int v, input int hb, input int vb,
                       input int short_line, input bit ramp);
    for (int l = 0; l < v; l++) begin
      for (int x = 0; x < ((l == short_line) ? h - 1 : h); x++)
        step(1'b1, ramp ? 16'(x) : 16'($urandom));
      lows(l == v - 1 ? vb : hb);
    end
  endtask
  task automatic do_reset(input int n);
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < n; i++) begin
      @(posedge lcd_pclk);
      #1;
      check("reset");
    end
    rst_n = 1'b1;
  endtask
  task automatic expect_meas(input string name, input int h, input int v);
    check_int({name, "_h"}, int'(meas_h_disp), h);
    check_int({name, "_v"}, int'(meas_v_disp), v);
    check_int({name, "_valid"}, int'(meas_valid), 1);
  endtask
  initial begin
    int le0, err0, pv0, fe0, fs0, h, v, sl, eh, ee;
    tbl[0] = '{20, 6, 5, 1100, -1, 1'b1, 20, 6};
    tbl[1] = '{1, 4, 3, 1030, -1, 1'b0, 1, 4};
    tbl[2] = '{32, 8, 1, 1024, -1, 1'b1, 32, 8};
    tbl[3] = '{16, 4, 1023, 1024, -1, 1'b0, 16, 4};
    tbl[4] = '{40, 10, 8, 1100, 5, 1'b1, 40, 10};
    tbl[5] = '{2100, 2, 10, 1024, -1, 1'b1, MAXC, 2};
    tbl[6] = '{12, 3, 2, 1024, 0, 1'b0, 11, 3};
    rst_n = 1'b0; lcd_de = 1'b0; lcd_rgb = '0;
    model_reset();
    do_reset(3);
    frame(10, 3, 4, 0, -1, 1'b0);
    lows(VB - 1);
    check_int("no_lock_1023", int'(locked), 0);
    check_int("no_pix_before_lock", n_pv, 0);
    lows(1);
    check_int("lock_1024", int'(locked), 1);
    for (int i = 0; i < 7; i++) begin
      le0 = n_le; err0 = n_err; pv0 = n_pv; fe0 = n_fe; fs0 = n_fs;
      frame(tbl[i].h, tbl[i].v, tbl[i].hb, tbl[i].vb, tbl[i].short_line, tbl[i].ramp);
      expect_meas($sformatf("tbl%0d", i), tbl[i].exp_h, tbl[i].exp_v);
      check_int($sformatf("tbl%0d_line_end", i), n_le - le0, tbl[i].v);
      check_int($sformatf("tbl%0d_pix", i), n_pv - pv0,
                tbl[i].h * tbl[i].v - (tbl[i].short_line >= 0 ? 1 : 0));
      check_int($sformatf("tbl%0d_fe", i), n_fe - fe0, 1);
      check_int($sformatf("tbl%0d_fs", i), n_fs - fs0, 1);
      check_int($sformatf("tbl%0d_err", i), n_err - err0,
                tbl[i].short_line == 0 ? tbl[i].v - 1 : (tbl[i].short_line > 0 ? 1 : 0));
    end
    for (int i = 0; i < 5; i++) step(1'b1, 16'($urandom));
    do_reset(3);
    check_int("rst_meas_valid", int'(meas_valid), 0);
    pv0 = n_pv;
    frame(10, 3, 4, 1100, -1, 1'b0);
    check_int("relock", int'(locked), 1);
    check_int("relock_no_pix", n_pv - pv0, 0);
    check_int("relock_meas_valid", int'(meas_valid), 0);
    frame(24, 5, 6, 1024, -1, 1'b1);
    expect_meas("after_relock", 24, 5);
    for (int r = 0; r < 8; r++) begin
      h = $urandom_range(2, 40); v = $urandom_range(1, 8);
      sl = $urandom_range(0, v);
      if (sl == v) sl = -1;
      eh = (sl == 0) ? h - 1 : h;
      ee = (sl == 0) ? v - 1 : (sl > 0 ? 1 : 0);
      err0 = n_err;
      frame(h, v, $urandom_range(1, 40), $urandom_range(VB, VB + 60), sl, 1'b0);
      expect_meas($sformatf("rand%0d", r), eh, v);
      check_int($sformatf("rand%0d_err", r), n_err - err0, ee);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_rgb_rx.md
Name: lcd_rgb_rx

Overview:
- DE-mode RGB565 LCD-interface receiver: the sink end of the panel timing stream produced by the LCD timing generator.
- HS/VS are tied high on this interface, so the block recovers frame and line structure from lcd_de alone.
- Emits per-pixel valid, data and x/y coordinates plus frame and line markers, and measures the active resolution.
- Used for loopback checking of the LCD path and for capturing an RGB stream into the frame buffer.

Parameters:
- VBLANK_MIN, 1024: consecutive DE-low cycles that declare vertical blank. Must exceed the longest horizontal blank (320) and be less than the shortest vertical blank (≥4 lines × 525).
- CNT_W, 11: width of the coordinate and measurement counters.

Ports:
- lcd_pclk  in  1  pixel clock; all inputs are synchronous to it.
- rst_n  in  1  asynchronous, active-low reset.
- lcd_de  in  1  data enable.
- lcd_rgb  in  16  RGB565 pixel; sampled only when lcd_de=1.
- pix_valid  out  1  pixel strobe.
- pix_data  out  16  captured pixel.
- pix_x  out  CNT_W  column of pix_data.
- pix_y  out  CNT_W  row of pix_data.
- frame_start  out  1  pulse, coincident with the first pixel of a frame.
- line_end  out  1  pulse, one cycle after the last pixel of a line.
- frame_end  out  1  pulse when vertical blank is detected after a frame.
- meas_h_disp  out  CNT_W  active pixels of line 0 of the last completed frame.
- meas_v_disp  out  CNT_W  active lines of the last completed frame.
- meas_valid  out  1  set at the first frame_end; stays set until reset.
- locked  out  1  receiver has seen a vertical blank.
- line_err  out  1  pulse with line_end when the line length differs from line 0.

Behaviour:
- Reset: asynchronous, active-low reset rst_n; clock lcd_pclk. All outputs and counters reset to 0; state SEEK.
- Inputs are sampled each lcd_pclk posedge. All outputs are registered, with 1-cycle latency from the sampled input to pix_* and the markers.
- low_cnt counts consecutive DE-low samples and saturates at VBLANK_MIN. It clears whenever DE is sampled high.
- SEEK:
  - DE is ignored; no pix_valid or markers.
  - When low_cnt reaches VBLANK_MIN → VBLANK, locked<=1.
  - locked never clears except on reset.
- VBLANK: DE sampled high → ACTIVE. Next cycle: pix_valid=1, pix_x=0, pix_y=0, frame_start=1. The y counter and line-0 reference are cleared.
- ACTIVE:
  - Each DE-high sample → pix_valid=1 next cycle, pix_data=lcd_rgb, pix_x increments by 1.
  - DE sampled low → HBLANK. Next cycle line_end=1.
  - Line length = pixel count of the line. On line 0 it is stored as ref_len; on later lines line_err=1 with line_end if length≠ref_len.
- HBLANK:
  - DE sampled high before low_cnt reaches VBLANK_MIN → ACTIVE. pix_y+1, pix_x restarts at 0.
  - low_cnt reaches VBLANK_MIN → VBLANK, and next cycle frame_end=1. In the same update meas_h_disp<=ref_len, meas_v_disp<=lines in frame, meas_valid<=1.
- Boundary conditions:
  - DE-low run of exactly VBLANK_MIN-1 cycles is a horizontal blank; a run of VBLANK_MIN is a vertical blank.
  - pix_x and pix_y saturate at 2^CNT_W-1; they never wrap.
  - A 1-pixel line is legal (line_end follows a single pix_valid).
  - Single-cycle DE-low gap: line_end on the low sample, pix_valid resumes the cycle after.
  - A frame still in progress at lock time is never emitted.
- Reset mid-frame: immediate return to SEEK, locked=0, meas_valid=0. The current frame is discarded.
- When pix_valid=0: pix_data, pix_x and pix_y hold their last values.

Test Plan:
- 480×272 stream (h_total 525, v_total 286, DE per 4342 timing), two frames → after the first frame_end: meas_h_disp=480, meas_v_disp=272, meas_valid=1. Frame 2: frame_start with x=0,y=0; last pixel x=479,y=271; exactly 272 line_end; 130560 pix_valid.
- Stream begins mid-frame (DE toggling at reset release) → no pix_valid or frame_start until ≥1024 DE-low cycles, then locked=1.
- DE-low gap of 1023 cycles inside a frame → no frame_end, y continues. Gap of 1024 → frame_end one cycle after the 1024th low sample.
- Line 5 carries 479 pixels in an 800×480 stream → line_err=1 on that line's line_end only. meas_h_disp=800, meas_v_disp=480.
- Pixel data ramp lcd_rgb=x → pix_data equals pix_x on every pix_valid (1-cycle latency check).
- rst_n low for 3 cycles mid-line → all outputs 0 during reset. Relock requires a fresh 1024-cycle blank.
